// File: rtl/serv_csr_seq_pkg.sv
// serv_csr_seq_pkg: shared state, CSR source and select encodings for the SERV CSR sequencer.
package serv_csr_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CSR,
      S_TRAP_EPC,
      S_TRAP_VEC,
      S_MRET
   } state_t;

   localparam logic [1:0] CSR_SOURCE_CSR = 2'b00;
   localparam logic [1:0] CSR_SOURCE_EXT = 2'b01;
   localparam logic [1:0] CSR_SOURCE_SET = 2'b10;
   localparam logic [1:0] CSR_SOURCE_CLR = 2'b11;

   localparam logic [2:0] CSR_SEL_MSTATUS = 3'b000;
   localparam logic [2:0] CSR_SEL_MIE     = 3'b001;
   localparam logic [2:0] CSR_SEL_MCAUSE  = 3'b010;

   localparam logic [1:0] RF_SEL_MTVEC = 2'b01;
   localparam logic [1:0] RF_SEL_MEPC  = 2'b10;

   // Set/clear with a zero operand must not write, so it degrades to a plain read.
   function automatic logic [1:0] csr_source(input logic [1:0] funct3, input logic rs1_zero);
      return (funct3 == 2'b01) ? CSR_SOURCE_EXT :
             (funct3[1] && !rs1_zero) ? (funct3[0] ? CSR_SOURCE_CLR : CSR_SOURCE_SET) :
             CSR_SOURCE_CSR;
   endfunction

endpackage

// File: rtl/serv_csr_seq_cnt.sv
// serv_csr_seq_cnt: 5-bit bit-serial counter with enable and gated position decodes.
module serv_csr_seq_cnt (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_cnt0to3,
   output logic o_cnt2,
   output logic o_cnt3,
   output logic o_cnt7,
   output logic o_cnt_done
);

   logic [4:0] cnt;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) cnt <= 5'd0;
      else if (i_en) cnt <= cnt + 5'd1;

   // Decodes are gated so the idle counter value never reaches the CSR block.
   assign o_cnt0to3  = i_en & (cnt < 5'd4);
   assign o_cnt2     = i_en & (cnt == 5'd2);
   assign o_cnt3     = i_en & (cnt == 5'd3);
   assign o_cnt7     = i_en & (cnt == 5'd7);
   assign o_cnt_done = i_en & (&cnt);

endmodule

// File: rtl/serv_csr_seq.sv
// serv_csr_seq: sequences CSR, trap and mret passes over the bit-serial CSR datapath.
// Define SERV_CSR_SEQ_IRQ_EN to latch timer interrupts and take irq-triggered traps.
module serv_csr_seq
   import serv_csr_seq_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_csr_req,
   input  logic [2:0] i_csr_sel,
   input  logic [1:0] i_funct3,
   input  logic       i_rs1_zero,
   input  logic       i_trap_req,
   input  logic       i_mret_req,
   input  logic       i_irq_window,
   input  logic       i_new_irq,
   output logic       o_ack,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_en,
   output logic       o_cnt0to3,
   output logic       o_cnt2,
   output logic       o_cnt3,
   output logic       o_cnt7,
   output logic       o_cnt_done,
   output logic       o_mstatus_en,
   output logic       o_mie_en,
   output logic       o_mcause_en,
   output logic       o_rf_csr_en,
   output logic [1:0] o_rf_csr_sel,
   output logic [1:0] o_csr_source,
   output logic       o_trap_taken,
   output logic       o_mret,
   output logic       o_pending_irq
);

   state_t state;
   logic   en, cnt_done, irq_trap, take_trap;

   assign en         = (state != S_IDLE);
   assign o_busy     = en;
   assign o_en       = en;
   assign o_done     = cnt_done;
   assign o_cnt_done = cnt_done;

   serv_csr_seq_cnt u_cnt (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_en       (en),
      .o_cnt0to3  (o_cnt0to3),
      .o_cnt2     (o_cnt2),
      .o_cnt3     (o_cnt3),
      .o_cnt7     (o_cnt7),
      .o_cnt_done (cnt_done)
   );

`ifdef SERV_CSR_SEQ_IRQ_EN
   assign irq_trap = o_pending_irq & i_irq_window;
   // A new irq arriving on the consuming cycle stays pending.
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) o_pending_irq <= 1'b0;
      else o_pending_irq <= i_new_irq | (o_pending_irq & ~(irq_trap & ~en));
`else
   logic unused_irq;
   assign unused_irq    = i_new_irq | i_irq_window;
   assign irq_trap      = 1'b0;
   assign o_pending_irq = 1'b0;
`endif

   assign take_trap = i_trap_req | irq_trap;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state        <= S_IDLE;
         o_ack        <= 1'b0;
         o_trap_taken <= 1'b0;
         o_mret       <= 1'b0;
         o_mstatus_en <= 1'b0;
         o_mie_en     <= 1'b0;
         o_mcause_en  <= 1'b0;
         o_rf_csr_en  <= 1'b0;
         o_rf_csr_sel <= 2'b00;
         o_csr_source <= CSR_SOURCE_CSR;
      end else begin
         o_ack        <= 1'b0;
         o_trap_taken <= 1'b0;
         o_mret       <= 1'b0;
         case (state)
            S_IDLE:
               if (take_trap) begin
                  state        <= S_TRAP_EPC;
                  o_ack        <= 1'b1;
                  o_trap_taken <= 1'b1;
                  o_rf_csr_en  <= 1'b1;
                  o_rf_csr_sel <= RF_SEL_MEPC;
                  o_csr_source <= CSR_SOURCE_EXT;
               end else if (i_mret_req) begin
                  state        <= S_MRET;
                  o_ack        <= 1'b1;
                  o_mret       <= 1'b1;
                  o_rf_csr_en  <= 1'b1;
                  o_rf_csr_sel <= RF_SEL_MEPC;
                  o_csr_source <= CSR_SOURCE_CSR;
               end else if (i_csr_req) begin
                  state        <= S_CSR;
                  o_ack        <= 1'b1;
                  o_mstatus_en <= (i_csr_sel == CSR_SEL_MSTATUS);
                  o_mie_en     <= (i_csr_sel == CSR_SEL_MIE);
                  o_mcause_en  <= (i_csr_sel == CSR_SEL_MCAUSE);
                  o_rf_csr_en  <= i_csr_sel[2];
                  o_rf_csr_sel <= i_csr_sel[2] ? i_csr_sel[1:0] : 2'b00;
                  o_csr_source <= csr_source(i_funct3, i_rs1_zero);
               end
            S_TRAP_EPC:
               if (cnt_done) begin
                  state        <= S_TRAP_VEC;
                  o_rf_csr_sel <= RF_SEL_MTVEC;
                  o_csr_source <= CSR_SOURCE_CSR;
               end
            default:
               if (cnt_done) begin
                  state        <= S_IDLE;
                  o_mstatus_en <= 1'b0;
                  o_mie_en     <= 1'b0;
                  o_mcause_en  <= 1'b0;
                  o_rf_csr_en  <= 1'b0;
                  o_rf_csr_sel <= 2'b00;
                  o_csr_source <= CSR_SOURCE_CSR;
               end
         endcase
      end

endmodule

// File: tb/tb_serv_csr_seq.sv
// tb_serv_csr_seq: randomized self-checking bench; expected per-cycle outputs come from a
// model of each request's 32/64-cycle pass schedule.
module tb_serv_csr_seq;

`ifdef SERV_CSR_SEQ_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic       i_clk = 1'b0;
   logic       i_rst_n = 1'b0;
   logic       i_csr_req = 1'b0;
   logic [2:0] i_csr_sel = 3'd0;
   logic [1:0] i_funct3 = 2'd0;
   logic       i_rs1_zero = 1'b0;
   logic       i_trap_req = 1'b0;
   logic       i_mret_req = 1'b0;
   logic       i_irq_window = 1'b0;
   logic       i_new_irq = 1'b0;
   logic       o_ack, o_busy, o_done, o_en, o_cnt0to3, o_cnt2, o_cnt3, o_cnt7, o_cnt_done;
   logic       o_mstatus_en, o_mie_en, o_mcause_en, o_rf_csr_en, o_trap_taken, o_mret, o_pending_irq;
   logic [1:0] o_rf_csr_sel, o_csr_source;

   int checks = 0;
   int failures = 0;

   always #5 i_clk = ~i_clk;

   serv_csr_seq dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_csr_req(i_csr_req), .i_csr_sel(i_csr_sel),
      .i_funct3(i_funct3), .i_rs1_zero(i_rs1_zero), .i_trap_req(i_trap_req),
      .i_mret_req(i_mret_req), .i_irq_window(i_irq_window), .i_new_irq(i_new_irq),
      .o_ack(o_ack), .o_busy(o_busy), .o_done(o_done), .o_en(o_en), .o_cnt0to3(o_cnt0to3),
      .o_cnt2(o_cnt2), .o_cnt3(o_cnt3), .o_cnt7(o_cnt7), .o_cnt_done(o_cnt_done),
      .o_mstatus_en(o_mstatus_en), .o_mie_en(o_mie_en), .o_mcause_en(o_mcause_en),
      .o_rf_csr_en(o_rf_csr_en), .o_rf_csr_sel(o_rf_csr_sel), .o_csr_source(o_csr_source),
      .o_trap_taken(o_trap_taken), .o_mret(o_mret), .o_pending_irq(o_pending_irq)
   );

   logic [18:0] obs;
   assign obs = {o_ack, o_busy, o_done, o_en, o_cnt0to3, o_cnt2, o_cnt3, o_cnt7, o_cnt_done,
                 o_mstatus_en, o_mie_en, o_mcause_en, o_rf_csr_en, o_rf_csr_sel, o_csr_source,
                 o_trap_taken, o_mret};

   // k = cycles since acceptance (1 = ack cycle); kind 0 CSR, 1 trap, 2 mret.
   function automatic logic [18:0] exp_vec(input int k, input int kind, input logic [2:0] sel,
                                           input logic [1:0] f3, input logic rz);
      int c, p, len;
      logic [2:0] ce;
      logic rfen;
      logic [1:0] rs, src;
      len = (kind == 1) ? 64 : 32;
      if (k < 1 || k > len) return 19'd0;
      c = (k - 1) % 32;
      p = (k - 1) / 32;
      ce = 3'b000; rfen = 1'b1; rs = 2'b10; src = 2'b00;
      if (kind == 0) begin
         ce   = (sel == 3'd0) ? 3'b100 : (sel == 3'd1) ? 3'b010 : (sel == 3'd2) ? 3'b001 : 3'b000;
         rfen = sel[2];
         rs   = sel[2] ? sel[1:0] : 2'b00;
         src  = (f3 == 2'd1) ? 2'b01 : (f3 == 2'd2 && !rz) ? 2'b10 : (f3 == 2'd3 && !rz) ? 2'b11 : 2'b00;
      end else if (kind == 1) begin
         rs  = (p == 0) ? 2'b10 : 2'b01;
         src = (p == 0) ? 2'b01 : 2'b00;
      end
      return {k == 1, 1'b1, c == 31, 1'b1, c < 4, c == 2, c == 3, c == 7, c == 31,
              ce, rfen, rs, src, kind == 1 && k == 1, kind == 2 && k == 1};
   endfunction

   task automatic test_reset;
      #3;
      checks++;
      if (obs !== 19'd0 || o_pending_irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_async got=%h pend=%b exp=0", obs, o_pending_irq);
      end
      repeat (2) @(posedge i_clk);
      #1;
      checks++;
      if (obs !== 19'd0 || o_pending_irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_held got=%h pend=%b exp=0", obs, o_pending_irq);
      end
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      checks++;
      if (obs !== 19'd0) begin
         failures++;
         $display("FAIL reset_idle got=%h exp=0", obs);
      end
   endtask

   task automatic test_csr_random;
      for (int t = 0; t < 10; t++) begin
         logic [2:0] s;
         logic [1:0] f;
         logic z;
         s = 3'($urandom_range(0, 7));
         f = 2'($urandom_range(0, 3));
         z = 1'($urandom_range(0, 1));
         if (t == 0) begin s = 3'd0; f = 2'd2; z = 1'b0; end
         if (t == 1) begin s = 3'd2; f = 2'd3; z = 1'b1; end
         if (t == 2) begin s = 3'd3; f = 2'd1; z = 1'b0; end
         i_csr_sel = s; i_funct3 = f; i_rs1_zero = z; i_csr_req = 1'b1;
         for (int k = 1; k <= 33; k++) begin
            logic [18:0] e;
            @(posedge i_clk);
            #1;
            e = exp_vec(k, 0, s, f, z);
            checks++;
            if (obs !== e) begin
               failures++;
               $display("FAIL csr t=%0d sel=%0d f3=%0d rz=%0b k=%0d got=%h exp=%h", t, s, f, z, k, obs, e);
            end
            if (k == 1) begin
               i_csr_req = 1'b0;
               i_csr_sel = 3'($urandom);
               i_funct3 = 2'($urandom);
               i_rs1_zero = 1'($urandom);
            end
         end
      end
   endtask

   task automatic test_priority;
      logic [2:0] s;
      logic [1:0] f;
      logic z;
      s = 3'($urandom_range(0, 7));
      f = 2'($urandom_range(0, 3));
      z = 1'($urandom_range(0, 1));
      i_csr_sel = s; i_funct3 = f; i_rs1_zero = z;
      i_trap_req = 1'b1; i_mret_req = 1'b1; i_csr_req = 1'b1;
      for (int k = 1; k <= 131; k++) begin
         logic [18:0] e;
         @(posedge i_clk);
         #1;
         e = (k <= 65) ? exp_vec(k, 1, s, f, z) :
             (k <= 98) ? exp_vec(k - 65, 2, s, f, z) : exp_vec(k - 98, 0, s, f, z);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL priority k=%0d got=%h exp=%h", k, obs, e);
         end
         if (k == 1) i_trap_req = 1'b0;
         if (k == 66) i_mret_req = 1'b0;
         if (k == 99) i_csr_req = 1'b0;
      end
   endtask

   task automatic test_mret_while_busy;
      logic [2:0] s;
      logic [1:0] f;
      logic z;
      s = 3'($urandom_range(4, 7));
      f = 2'($urandom_range(0, 3));
      z = 1'($urandom_range(0, 1));
      i_csr_sel = s; i_funct3 = f; i_rs1_zero = z; i_csr_req = 1'b1;
      for (int k = 1; k <= 66; k++) begin
         logic [18:0] e;
         @(posedge i_clk);
         #1;
         e = (k <= 33) ? exp_vec(k, 0, s, f, z) : exp_vec(k - 33, 2, s, f, z);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL mret_busy k=%0d got=%h exp=%h", k, obs, e);
         end
         if (k == 1) i_csr_req = 1'b0;
         if (k == 5) i_mret_req = 1'b1;
         if (k == 34) i_mret_req = 1'b0;
      end
   endtask

   task automatic test_irq;
      i_new_irq = 1'b1;
      @(posedge i_clk);
      #1;
      i_new_irq = 1'b0;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (o_pending_irq !== IRQ_EN || obs !== 19'd0) begin
            failures++;
            $display("FAIL irq_latch k=%0d pend=%b exp=%b got=%h", k, o_pending_irq, IRQ_EN, obs);
         end
         @(posedge i_clk);
         #1;
      end
      i_irq_window = 1'b1;
      for (int k = 1; k <= 65; k++) begin
         logic [18:0] e;
         @(posedge i_clk);
         #1;
         if (k == 1) i_irq_window = 1'b0;
         e = IRQ_EN ? exp_vec(k, 1, 3'd0, 2'd0, 1'b0) : 19'd0;
         checks++;
         if (obs !== e || o_pending_irq !== 1'b0) begin
            failures++;
            $display("FAIL irq_trap k=%0d got=%h exp=%h pend=%b exp=0", k, obs, e, o_pending_irq);
         end
      end
      i_new_irq = 1'b1;
      @(posedge i_clk);
      #1;
      i_irq_window = 1'b1;
      for (int k = 1; k <= 65; k++) begin
         logic [18:0] e;
         @(posedge i_clk);
         #1;
         if (k == 1) begin i_irq_window = 1'b0; i_new_irq = 1'b0; end
         e = IRQ_EN ? exp_vec(k, 1, 3'd0, 2'd0, 1'b0) : 19'd0;
         checks++;
         if (obs !== e || o_pending_irq !== IRQ_EN) begin
            failures++;
            $display("FAIL irq_set_wins k=%0d got=%h exp=%h pend=%b exp=%b", k, obs, e, o_pending_irq, IRQ_EN);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [2:0] s;
      logic [1:0] f;
      logic z;
      s = 3'($urandom_range(0, 7));
      f = 2'($urandom_range(0, 3));
      z = 1'($urandom_range(0, 1));
      i_csr_sel = s; i_funct3 = f; i_rs1_zero = z; i_csr_req = 1'b1;
      for (int k = 1; k <= 16; k++) begin
         @(posedge i_clk);
         #1;
         if (k == 1) i_csr_req = 1'b0;
      end
      checks++;
      if (obs !== exp_vec(16, 0, s, f, z)) begin
         failures++;
         $display("FAIL pre_reset got=%h exp=%h", obs, exp_vec(16, 0, s, f, z));
      end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if (obs !== 19'd0 || o_pending_irq !== 1'b0) begin
         failures++;
         $display("FAIL reset_mid_async got=%h pend=%b exp=0", obs, o_pending_irq);
      end
      @(posedge i_clk);
      #4 i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      s = 3'($urandom_range(0, 7));
      f = 2'($urandom_range(0, 3));
      z = 1'($urandom_range(0, 1));
      i_csr_sel = s; i_funct3 = f; i_rs1_zero = z; i_csr_req = 1'b1;
      for (int k = 1; k <= 33; k++) begin
         logic [18:0] e;
         @(posedge i_clk);
         #1;
         if (k == 1) i_csr_req = 1'b0;
         e = exp_vec(k, 0, s, f, z);
         checks++;
         if (obs !== e) begin
            failures++;
            $display("FAIL after_reset k=%0d got=%h exp=%h", k, obs, e);
         end
      end
   endtask

   initial begin
      test_reset;
      test_csr_random;
      test_priority;
      test_mret_while_busy;
      test_irq;
      test_reset_mid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
